// File: rtl/delay_pkg.sv
// delay_pkg: shared FSM state encoding and parameter defaults for the fall-delay cell
package delay_pkg;
  localparam int DLY_W_DEF = 8;
  localparam int FILT_W_DEF = 8;
  localparam int SYNC_STAGES_DEF = 2;
  typedef enum logic [1:0] {LOW, HIGH, COUNT} state_t;
endpackage

// File: rtl/delay_sync.sv
// delay_sync: multi-flop synchronizer with asynchronous active-low clear
module delay_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] ff;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= '0;
    else ff <= {ff[SYNC_STAGES-2:0], d};
  assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/delay_fall_prog.sv
// delay_fall_prog: passes rising edges after sync, delays falls by a programmable count,
// and counts low pulses that end before the delay expires.
module delay_fall_prog
  import delay_pkg::*;
#(
  parameter int DLY_W = DLY_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_W = FILT_W_DEF
) (
  input  logic              CELCLK,
  input  logic              CELRSTN,
  input  logic              CELV,
  input  logic              CELG,
  input  logic              CELSUB,
  input  logic              i,
  input  logic [DLY_W-1:0]  dly_sel,
  output logic              o,
  output logic              busy,
  output logic              done,
  output logic [FILT_W-1:0] filt_cnt
);
  state_t state;
  logic [DLY_W-1:0] cnt;
  logic i_s;
  logic unused_pins;
  assign unused_pins = CELV ^ CELG ^ CELSUB;
  delay_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(CELCLK), .rst_n(CELRSTN), .d(i), .q(i_s)
  );
  // abort on i_s=1 is checked before expiry so a returning high always wins
  always_ff @(posedge CELCLK or negedge CELRSTN)
    if (!CELRSTN) begin
      state <= LOW;
      o <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      filt_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        LOW: if (i_s) begin
          state <= HIGH;
          o <= 1'b1;
        end
        HIGH: if (!i_s) begin
          state <= COUNT;
          cnt <= dly_sel;
          busy <= 1'b1;
        end
        COUNT: if (i_s) begin
          state <= HIGH;
          busy <= 1'b0;
          if (~&filt_cnt) filt_cnt <= filt_cnt + FILT_W'(1);
        end else if (cnt == '0) begin
          state <= LOW;
          o <= 1'b0;
          done <= 1'b1;
          busy <= 1'b0;
        end else cnt <= cnt - DLY_W'(1);
        default: state <= LOW;
      endcase
    end
endmodule

// File: tb/tb_delay_fall_prog.sv
// tb_delay_fall_prog: directed stimulus queues expected output events; a monitor pops and compares them.
module tb_delay_fall_prog;
  localparam int S = 2;
  localparam int EV_RISE = 0, EV_BUSY = 1, EV_FALL = 2, EV_STRAY = 3;
  typedef struct {int kind; int cyc; int val;} ev_t;
  logic clk = 1'b0;
  logic rst_n;
  logic i;
  logic [7:0] dly_sel;
  logic o, busy, done;
  logic [7:0] filt_cnt;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int f_model = 0;
  int prev_o = 0;
  int run = 0;
  ev_t exp_q[$];

  delay_fall_prog dut (
    .CELCLK(clk), .CELRSTN(rst_n), .CELV(1'b1), .CELG(1'b0), .CELSUB(1'b0),
    .i(i), .dly_sel(dly_sel), .o(o), .busy(busy), .done(done), .filt_cnt(filt_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic push(input int kind, input int c, input int v);
    ev_t e;
    e.kind = kind;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic got(input int kind, input int c, input int v);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d cyc %0d val %0d, expected none", kind, c, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind != EV_BUSY && e.cyc != c) || e.val != v) begin
        n_bad++;
        $display("FAIL event: got kind %0d cyc %0d val %0d, expected kind %0d cyc %0d val %0d",
                 kind, c, v, e.kind, e.cyc, e.val);
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hi();
    i = 1'b1;
    push(EV_RISE, cyc + S + 1, 0);
    cycles(S + 3);
  endtask

  task automatic fall(input int d, input int d2);
    dly_sel = 8'(d);
    i = 1'b0;
    push(EV_BUSY, 0, d + 1);
    push(EV_FALL, cyc + S + 2 + d, 1);
    cycles(S + 2);
    dly_sel = 8'(d2);
    cycles(d + 3);
  endtask

  task automatic pulse(input int d, input int len);
    int c;
    c = cyc;
    dly_sel = 8'(d);
    i = 1'b0;
    if (len <= d + 1) begin
      push(EV_BUSY, 0, len);
      f_model = (f_model == 255) ? 255 : f_model + 1;
    end else begin
      push(EV_BUSY, 0, d + 1);
      push(EV_FALL, c + S + 2 + d, 1);
      push(EV_RISE, c + len + S + 1, 0);
    end
    cycles(len);
    i = 1'b1;
    cycles(d + S + 4);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_o = 0;
        run = 0;
      end else begin
        if (o && prev_o == 0) got(EV_RISE, cyc, int'(done));
        if (!busy && run > 0) begin
          got(EV_BUSY, 0, run);
          run = 0;
        end
        if (busy) run++;
        if (!o && prev_o == 1) got(EV_FALL, cyc, int'(done));
        else if (done) got(EV_STRAY, cyc, 1);
        prev_o = int'(o);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    i = 1'b1;
    dly_sel = 8'd0;
    cycles(3);
    chk("rst_o", o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_filt", filt_cnt, 0);
    i = 1'b0;
    #1 rst_n = 1'b1;
    cycles(3);
    hi();
    fall(5, 5);
    hi();
    pulse(10, 4);
    chk("filter_filt", filt_cnt, f_model);
    chk("filter_o", o, 1);
    fall(0, 0);
    hi();
    pulse(0, 2);
    chk("min_pass_filt", filt_cnt, f_model);
    fall(3, 50);
    hi();
    for (int k = 0; k < 300; k++) pulse(3, 2);
    chk("sat_filt", filt_cnt, 255);
    chk("sat_model", filt_cnt, f_model);
    dly_sel = 8'd20;
    i = 1'b0;
    cycles(S + 1 + 7);
    chk("mid_busy", busy, 1);
    chk("mid_o", o, 1);
    #2 rst_n = 1'b0;
    i = 1'b1;
    #1;
    chk("arst_o", o, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_filt", filt_cnt, 0);
    cycles(2);
    chk("hold_o", o, 0);
    #1 rst_n = 1'b1;
    push(EV_RISE, cyc + S + 1, 0);
    cycles(S + 5);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
